// File: rtl/fetch_unit_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package fetch_unit_pkg;

   // Default widths; these must match the instruction memory the stage feeds.
   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_ADDR_WIDTH = 10;

   // Depth of the skid buffer between fetch and decode.
   localparam int SKID_DEPTH = 2;

   // Instruction word presented on the decode port when nothing valid is held.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // A new fetch may be issued only when every word already owed to the buffer
   // (held words plus the in-flight word, less the one leaving this edge) still
   // leaves room, so a landing word never meets a full buffer.
   function automatic logic issue_credit(input logic [1:0] count,
                                         input logic       inflight,
                                         input logic       pop);
      logic [2:0] occupancy;
      occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
      return occupancy < 3'(SKID_DEPTH);
   endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry registered FIFO of {instr, pc}; the head slot drives decode directly.
module fetch_skid_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_instr,
   input  logic [ADDR_WIDTH-1:0] push_pc,
   input  logic                  pop,
   output logic [1:0]            count,
   output logic                  head_valid,
   output logic [DATA_WIDTH-1:0] head_instr,
   output logic [ADDR_WIDTH-1:0] head_pc
);

   logic                  valid0_q;
   logic                  valid1_q;
   logic [DATA_WIDTH-1:0] instr0_q;
   logic [DATA_WIDTH-1:0] instr1_q;
   logic [ADDR_WIDTH-1:0] pc0_q;
   logic [ADDR_WIDTH-1:0] pc1_q;

   // Slot 1 is only ever valid while slot 0 is, so the count is a simple encode.
   assign count      = {valid0_q & valid1_q, valid0_q ^ valid1_q};
   assign head_valid = valid0_q;
   assign head_instr = instr0_q;
   assign head_pc    = pc0_q;

   // Shift slot 1 into the head on a pop and place the pushed word in the first free slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
         instr0_q <= DATA_WIDTH'(NOP_INSTR);
         instr1_q <= DATA_WIDTH'(NOP_INSTR);
         pc0_q    <= '0;
         pc1_q    <= '0;
      end else if (flush) begin
         valid0_q <= 1'b0;
         valid1_q <= 1'b0;
      end else if (pop && push) begin
         if (valid1_q) begin
            instr0_q <= instr1_q;
            pc0_q    <= pc1_q;
            instr1_q <= push_instr;
            pc1_q    <= push_pc;
         end else begin
            instr0_q <= push_instr;
            pc0_q    <= push_pc;
         end
      end else if (pop) begin
         instr0_q <= instr1_q;
         pc0_q    <= pc1_q;
         valid0_q <= valid1_q;
         valid1_q <= 1'b0;
      end else if (push) begin
         if (!valid0_q) begin
            instr0_q <= push_instr;
            pc0_q    <= push_pc;
            valid0_q <= 1'b1;
         end else begin
            instr1_q <= push_instr;
            pc1_q    <= push_pc;
            valid1_q <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, hides the memory's one-cycle read latency
// and hands {instr, pc} to decode through a two-entry skid buffer.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int                    ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_en,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   input  logic [DATA_WIDTH-1:0] imem_data,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  id_valid,
   input  logic                  id_ready,
   output logic [DATA_WIDTH-1:0] id_instr,
   output logic [ADDR_WIDTH-1:0] id_pc
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(1);

   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] inflight_pc_q;
   logic                  inflight_q;
   logic [1:0]            fifo_count;
   logic                  pop;
   logic                  push;
   logic                  issue;

   // The memory reads whatever the PC register holds; it only matters on issue edges.
   assign imem_addr = pc_q;

   // A redirect kills both the in-flight word and any head being accepted.
   assign pop   = id_valid & id_ready;
   assign push  = inflight_q & ~redirect_valid;
   assign issue = fetch_en & ~redirect_valid & issue_credit(fifo_count, inflight_q, pop);

   // Redirect takes priority over issue; the PC wraps naturally at 2^ADDR_WIDTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else if (redirect_valid) begin
         pc_q       <= redirect_pc;
         inflight_q <= 1'b0;
      end else if (issue) begin
         inflight_q    <= 1'b1;
         inflight_pc_q <= pc_q;
         pc_q          <= pc_q + PC_STEP;
      end else begin
         inflight_q <= 1'b0;
      end
   end

   fetch_skid_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .flush      (redirect_valid),
      .push       (push),
      .push_instr (imem_data),
      .push_pc    (inflight_pc_q),
      .pop        (pop),
      .count      (fifo_count),
      .head_valid (id_valid),
      .head_instr (id_instr),
      .head_pc    (id_pc)
   );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus queues the expected {instr, pc}
// stream, a negedge monitor pops and compares every accepted word.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        fetch_en = 1'b0;
   logic [9:0]  imem_addr;
   logic [31:0] imem_data = 32'h0;
   logic        redirect_valid = 1'b0;
   logic [9:0]  redirect_pc = 10'd0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_instr;
   logic [9:0]  id_pc;

   typedef struct packed {
      logic [31:0] instr;
      logic [9:0]  pc;
   } expWord_t;

   expWord_t expQ[$];
   expWord_t monEntry;
   int       errors = 0;
   int       checks = 0;
   int       drainCycles;

   fetch_unit #(
      .DATA_WIDTH (32),
      .ADDR_WIDTH (10),
      .RESET_PC   (10'd0)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_data      (imem_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Instruction memory contents: hand-picked words at 0..3, address-tagged elsewhere.
   function automatic logic [31:0] memWord(input logic [9:0] a);
      case (a)
         10'd0:   return 32'h0000_0011;
         10'd1:   return 32'h0000_0022;
         10'd2:   return 32'h0000_0033;
         10'd3:   return 32'h0000_0044;
         default: return 32'hC000_0000 | {22'h0, a};
      endcase
   endfunction

   // Synchronous-read memory model: data for the address seen at an edge appears after it.
   always @(posedge clk) imem_data <= memWord(imem_addr);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic fe, input logic rdy, input logic rv, input logic [9:0] rpc);
      fetch_en       = fe;
      id_ready       = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
   endtask

   task automatic pushExp(input logic [9:0] pc);
      expQ.push_back('{instr: memWord(pc), pc: pc});
   endtask

   // Wait, bounded, until the monitor has consumed every queued expectation.
   task automatic waitDrain(output int cycles);
      cycles = 0;
      while (expQ.size() != 0 && cycles < 40) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      if (expQ.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d words still expected, required 0", expQ.size());
         expQ.delete();
      end
   endtask

   // Monitor: a handshake counts when valid & ready with no redirect killing the head.
   always @(negedge clk) begin
      if (!rst && id_valid && id_ready && !redirect_valid) begin
         if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word: got pc %0d instr 0x%0h, required no word", id_pc, id_instr);
         end else begin
            monEntry = expQ.pop_front();
            checkOutput("mon_pc", 32'(id_pc), 32'(monEntry.pc));
            checkOutput("mon_instr", id_instr, monEntry.instr);
         end
      end
   end

   // Release reset and stream words 0..3 with decode always ready.
   task automatic runStream();
      for (int i = 0; i < 4; i++) pushExp(10'(i));
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      checkOutput("lat_edge1_valid", 32'(id_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("lat_edge2_valid", 32'(id_valid), 32'd1);
      checkOutput("lat_edge2_pc", 32'(id_pc), 32'd0);
      checkOutput("lat_edge2_instr", id_instr, 32'h11);
      waitDrain(drainCycles);
      checkOutput("stream_cycles", 32'(drainCycles), 32'd4);
      @(posedge clk); #1;
      id_ready = 1'b0;
   endtask

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenario sequence.
   initial begin
      #1 rst = 1'b1;
      #10;
      checkOutput("reset_valid", 32'(id_valid), 32'd0);
      checkOutput("reset_instr", id_instr, 32'd0);
      checkOutput("reset_pc", 32'(id_pc), 32'd0);
      checkOutput("reset_addr", 32'(imem_addr), 32'd0);

      // Free-running stream of the first four words.
      runStream();

      // Asynchronous reset mid-stream, between edges, then an identical restart.
      #2 rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 32'(id_valid), 32'd0);
      checkOutput("midrst_addr", 32'(imem_addr), 32'd0);
      checkOutput("midrst_pc", 32'(id_pc), 32'd0);
      runStream();

      // Backpressure: decode stalls from the start, buffer fills, issue stops.
      #2 rst = 1'b1;
      for (int i = 0; i < 4; i++) pushExp(10'(i));
      applyStimulus(1'b1, 1'b0, 1'b0, 10'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      checkOutput("bp_first_valid", 32'(id_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checkOutput("bp_hold_pc", 32'(id_pc), 32'd0);
         checkOutput("bp_hold_instr", id_instr, 32'h11);
      end
      checkOutput("bp_addr_stopped", 32'(imem_addr), 32'd2);
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      waitDrain(drainCycles);
      checkOutput("bp_release_cycles", 32'(drainCycles), 32'd4);
      @(posedge clk); #1;
      id_ready = 1'b0;

      // Redirect while the buffer is full; the buffered words must never appear.
      repeat (3) @(posedge clk);
      #1;
      checkOutput("redir_full_valid", 32'(id_valid), 32'd1);
      for (int i = 20; i < 23; i++) pushExp(10'(i));
      applyStimulus(1'b1, 1'b1, 1'b1, 10'd20);
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      checkOutput("redir_edge1_valid", 32'(id_valid), 32'd0);
      @(posedge clk); #1;
      checkOutput("redir_edge2_valid", 32'(id_valid), 32'd0);
      checkOutput("redir_edge2_addr", 32'(imem_addr), 32'd21);
      waitDrain(drainCycles);
      @(posedge clk); #1;
      id_ready = 1'b0;

      // Back-to-back redirects: only the second target is fetched.
      pushExp(10'd200);
      pushExp(10'd201);
      applyStimulus(1'b1, 1'b1, 1'b1, 10'd100);
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 1'b1, 10'd200);
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      checkOutput("b2b_addr", 32'(imem_addr), 32'd200);
      waitDrain(drainCycles);
      @(posedge clk); #1;
      id_ready = 1'b0;

      // PC wrap-around at the top of the address space.
      pushExp(10'd1022);
      pushExp(10'd1023);
      pushExp(10'd0);
      pushExp(10'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 10'd1022);
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      waitDrain(drainCycles);
      @(posedge clk); #1;

      // fetch_en drops mid-stream: in-flight words land, then the stage idles.
      pushExp(10'd50);
      pushExp(10'd51);
      applyStimulus(1'b1, 1'b1, 1'b1, 10'd50);
      @(posedge clk); #1;
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b1, 1'b0, 10'd0);
      waitDrain(drainCycles);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 10'd0);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("fe_off_valid", 32'(id_valid), 32'd0);
      checkOutput("fe_off_addr", 32'(imem_addr), 32'd52);
      @(posedge clk); #1;
      checkOutput("fe_off_addr_hold", 32'(imem_addr), 32'd52);
      pushExp(10'd52);
      pushExp(10'd53);
      applyStimulus(1'b1, 1'b1, 1'b0, 10'd0);
      waitDrain(drainCycles);
      @(posedge clk); #1;
      applyStimulus(1'b0, 1'b0, 1'b0, 10'd0);
      repeat (2) @(posedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
